// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit
//   Iterative RV32M/RV64M execution unit for the EX stage. Implements
//   MUL/MULH/MULHSU/MULHU with shift-add and DIV/DIVU/REM/REMU with restoring
//   division. Both retire UNROLL bits per cycle. Divide-by-zero and signed
//   overflow are resolved at accept time and bypass the iteration entirely.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           drop any in-flight operation, return to IDLE
//   in_valid/ready  request handshake (ready only in IDLE, out of reset)
//   in_funct3       RISC-V M-extension funct3 (000 MUL .. 111 REMU)
//   in_rs1, in_rs2  operands
//   in_tag          destination tag carried with the operation
//   out_valid/ready result handshake (valid held in DONE until ready)
//   out_result      result, holds its last value while out_valid=0
//   out_tag         tag of out_result
//   busy            unit is not idle
module rv_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_next;
  logic               accept;

  logic [2:0]         funct3_q;
  logic [TAG_W-1:0]   tag_q;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic               neg_q, neg_r;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {partial high (XLEN+1), multiplier shifting out (XLEN)}.
  // Divide:   {partial remainder (XLEN+1), dividend/quotient (XLEN)}.
  logic [2*XLEN:0]    acc;

  logic               signed1, signed2, neg1, neg2;
  logic [XLEN-1:0]    mag1, mag2;
  logic               special;
  logic [XLEN-1:0]    special_result;

  logic [2*XLEN:0]    step;
  logic [XLEN+1:0]    trial;
  logic [2*XLEN-1:0]  prod_s;
  logic [XLEN-1:0]    fix_result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs; flush overrides everything, and a
  // flushed cycle never accepts even though in_ready stays up.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    in_ready   = (state == IDLE) && !rst;
    busy       = (state != IDLE) && !rst;
    out_valid  = (state == DONE);
    accept     = in_valid && in_ready && !flush;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Operand decode: signedness per funct3, magnitudes, and the two cases
  // whose answer is fixed by the ISA without iterating.
  always_comb begin
    signed1 = !((in_funct3 == 3'b011) || (in_funct3[2] && in_funct3[0]));
    signed2 = (!in_funct3[2] && !in_funct3[1]) || (in_funct3[2] && !in_funct3[0]);
    neg1    = signed1 && in_rs1[XLEN-1];
    neg2    = signed2 && in_rs2[XLEN-1];
    mag1    = neg1 ? -in_rs1 : in_rs1;
    mag2    = neg2 ? -in_rs2 : in_rs2;
    special = 1'b0;
    special_result = '0;
    if (in_funct3[2]) begin
      if (in_rs2 == '0) begin
        special = 1'b1;
        special_result = in_funct3[1] ? in_rs1 : {XLEN{1'b1}};
      end else if (!in_funct3[0] && (in_rs1 == MIN_INT) && (in_rs2 == {XLEN{1'b1}})) begin
        special = 1'b1;
        special_result = in_funct3[1] ? '0 : MIN_INT;
      end
    end
  end

  // One cycle of iteration: UNROLL shift-add steps (LSB first) or UNROLL
  // restoring-division steps (MSB first). The partial field is one bit
  // wider than XLEN so the add carry / shifted remainder never overflows.
  always_comb begin
    step  = acc;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (funct3_q[2]) begin
        step  = step << 1;
        trial = {1'b0, step[2*XLEN:XLEN]} - {2'b00, b_mag};
        if (!trial[XLEN+1]) begin
          step[2*XLEN:XLEN] = trial[XLEN:0];
          step[0] = 1'b1;
        end
      end else begin
        if (step[0]) step[2*XLEN:XLEN] = step[2*XLEN:XLEN] + {1'b0, a_mag};
        step = step >> 1;
      end
    end
  end

  // Sign fixup and result selection, registered on the CALC->DONE edge.
  always_comb begin
    prod_s     = neg_q ? -step[2*XLEN-1:0] : step[2*XLEN-1:0];
    fix_result = '0;
    if (!funct3_q[2]) begin
      fix_result = (funct3_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (funct3_q[1]) begin
      fix_result = neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    end else begin
      fix_result = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    end
  end

  // Datapath registers. Multiply keeps the multiplicand in a_mag and shifts
  // the multiplier through acc; divide keeps the divisor in b_mag and
  // shifts the dividend through acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q   <= '0;
      tag_q      <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      funct3_q <= in_funct3;
      tag_q    <= in_tag;
      a_mag    <= mag1;
      b_mag    <= mag2;
      neg_q    <= neg1 ^ neg2;
      neg_r    <= neg1;
      cnt      <= CNT_W'(ITERS - 1);
      acc      <= {1'b0, {XLEN{1'b0}}, (in_funct3[2] ? mag1 : mag2)};
      if (special) begin
        out_result <= special_result;
        out_tag    <= in_tag;
      end
    end else if ((state == CALC) && !flush) begin
      acc <= step;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        out_result <= fix_result;
        out_tag    <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit
//   Directed bench for rv_muldiv_unit. Two instances (UNROLL=1 and UNROLL=4,
//   XLEN=32) share all inputs so every operation is checked for both
//   iteration widths, including latency from the accept edge.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_tag;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_result1;
  logic [4:0]  out_tag1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_result4;
  logic [4:0]  out_tag4;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat1, lat4, hi1, hi4;
  logic [31:0] res1, res4;
  logic [4:0]  tg1, tg4;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          l1;
    int          l4;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1),
    .out_tag(out_tag1), .busy(busy1)
  );

  rv_muldiv_unit #(.XLEN(32), .UNROLL(4), .TAG_W(5)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_tag(out_tag4), .busy(busy4)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Waits (bounded) for both units to be idle, then presents one request
  // for exactly one cycle. Returns just after the accept edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] t);
    int w;
    w = 0;
    @(negedge clk);
    while (!(in_ready1 && in_ready4) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready_before_accept", {62'd0, in_ready1, in_ready4}, 64'd3);
    in_funct3 = f;
    in_rs1    = a;
    in_rs2    = b;
    in_tag    = t;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issues an op and watches 40 cycles, recording the first cycle (relative
  // to the accept edge) each unit shows out_valid and for how many cycles.
  task automatic runOp(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    applyStimulus(f, a, b, t);
    lat1 = -1; lat4 = -1; hi1 = 0; hi4 = 0;
    res1 = '0; res4 = '0; tg1 = '0; tg4 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid1 === 1'b1) begin
        if (lat1 < 0) begin lat1 = k; res1 = out_result1; tg1 = out_tag1; end
        hi1++;
      end
      if (out_valid4 === 1'b1) begin
        if (lat4 < 0) begin lat4 = k; res4 = out_result4; tg4 = out_tag4; end
        hi4++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit stable;
    int seen;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 9};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 9};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 9};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 9};
    vecs[4]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1};
    vecs[5]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1};
    vecs[6]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1};
    vecs[7]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1, 1};
    vecs[8]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 9};
    vecs[9]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 9};
    vecs[10] = '{3'd4, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, 9};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", {62'd0, in_ready1, in_ready4}, 64'd0);
    checkOutput("rst_busy", {62'd0, busy1, busy4}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_out_valid", {62'd0, out_valid1, out_valid4}, 64'd0);
    checkOutput("post_rst_out_result", {out_result1, out_result4}, 64'd0);
    checkOutput("post_rst_out_tag", {54'd0, out_tag1, out_tag4}, 64'd0);
    checkOutput("post_rst_in_ready", {62'd0, in_ready1, in_ready4}, 64'd3);

    // Directed operation table, both unroll factors
    for (int i = 0; i < 11; i++) begin
      runOp(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1));
      checkOutput($sformatf("v%0d_result_u1", i), res1, vecs[i].exp);
      checkOutput($sformatf("v%0d_result_u4", i), res4, vecs[i].exp);
      checkOutput($sformatf("v%0d_latency_u1", i), lat1, vecs[i].l1);
      checkOutput($sformatf("v%0d_latency_u4", i), lat4, vecs[i].l4);
      checkOutput($sformatf("v%0d_tag", i), {54'd0, tg1, tg4}, {54'd0, 5'(i + 1), 5'(i + 1)});
      checkOutput($sformatf("v%0d_valid_cycles", i), {hi1[7:0], hi4[7:0]}, 16'h0101);
    end

    // Backpressure: MUL 6*7 held in DONE for 10 cycles
    out_ready = 1'b0;
    applyStimulus(3'd0, 32'd6, 32'd7, 5'd9);
    seen = 0;
    while ((out_valid1 !== 1'b1) && (seen < 50)) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("bp_result_u1", {out_valid1, out_result1}, {1'b1, 32'h2A});
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!(out_valid1 === 1'b1 && out_result1 === 32'h2A && out_tag1 === 5'd9 && in_ready1 === 1'b0 &&
            out_valid4 === 1'b1 && out_result4 === 32'h2A && out_tag4 === 5'd9 && in_ready4 === 1'b0))
        stable = 1'b0;
    end
    checkOutput("bp_held_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {62'd0, out_valid1, out_valid4}, 64'd0);
    checkOutput("bp_release_in_ready", {62'd0, in_ready1, in_ready4}, 64'd3);
    checkOutput("bp_release_result_kept", {out_result1, out_result4}, {32'h2A, 32'h2A});

    // Flush in the same cycle as a request: request must not be taken
    in_funct3 = 3'd5; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'd30;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    checkOutput("flush_accept_in_ready", {62'd0, in_ready1, in_ready4}, 64'd3);
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_accept_not_taken", {62'd0, busy1, busy4}, 64'd0);

    // Flush at CALC cycle 5
    applyStimulus(3'd5, 32'd1000, 32'd3, 5'd4);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_in_ready", {62'd0, in_ready1, in_ready4}, 64'd3);
    checkOutput("flush_busy", {62'd0, busy1, busy4}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0) seen++;
    end
    checkOutput("flush_no_result", seen, 0);

    runOp(3'd5, 32'd100, 32'd7, 5'd17);
    checkOutput("after_flush_result", {res1, res4}, {32'd14, 32'd14});
    checkOutput("after_flush_tag", {54'd0, tg1, tg4}, {54'd0, 5'd17, 5'd17});
    checkOutput("after_flush_latency_u1", lat1, 33);
    checkOutput("after_flush_latency_u4", lat4, 9);

    // Reset mid-CALC
    applyStimulus(3'd0, 32'd5, 32'd5, 5'd2);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_in_ready", {62'd0, in_ready1, in_ready4}, 64'd0);
    checkOutput("mid_rst_busy", {62'd0, busy1, busy4}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_out_result", {out_result1, out_result4}, 64'd0);
    checkOutput("mid_rst_out_tag", {54'd0, out_tag1, out_tag4}, 64'd0);
    checkOutput("mid_rst_out_valid", {62'd0, out_valid1, out_valid4}, 64'd0);
    checkOutput("mid_rst_in_ready_after", {62'd0, in_ready1, in_ready4}, 64'd3);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0) seen++;
    end
    checkOutput("mid_rst_no_result", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised iterative RV32M/RV64M execution unit that implements all eight M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the EX stage beside the ALU and is fed by the M-extension decoder with funct3, operands and destination tag.
- Uses a valid/ready handshake on both sides, plus a pipeline flush.
- Replaces single-cycle decode-only M support with a multi-cycle datapath: configurable bits per cycle and RISC-V-exact special cases.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- UNROLL, 1, multiply/divide bits retired per cycle; must divide XLEN (1, 2, 4 or 8).
- TAG_W, 5, width of the destination tag carried alongside the operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill any in-flight operation (synchronous).
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- in_funct3  in  3  M-op select (000 MUL … 111 REMU, RISC-V encoding).
- in_rs1  in  XLEN  operand 1.
- in_rs2  in  XLEN  operand 2.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, out_valid=0, out_result=0, out_tag=0. While rst=1, in_ready=0 and busy=0.
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- in_ready=1 only in IDLE with rst=0. Accept = in_valid & in_ready. No back-to-back overlap.
- On accept, register funct3, tag, sign flags and operand magnitudes.
  - rs1 is signed for MUL/MULH/MULHSU/DIV/REM.
  - rs2 is signed for MUL/MULH/DIV/REM.
  - A negative signed operand is stored as its two's-complement magnitude.
- Multiply:
  - Shift-add, UNROLL bits of rs2 per cycle, into a 2*XLEN accumulator.
  - Negate the product if the two operand signs differ.
  - MUL returns bits [XLEN-1:0]; the MULH variants return [2XLEN-1:XLEN].
- Divide:
  - Restoring division, UNROLL quotient bits per cycle, MSB first.
  - Quotient is negated if sign1^sign2 (signed ops). Remainder takes the sign of rs1.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, detected at accept and skipping CALC (IDLE→DONE next cycle):
  - rs2==0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = MIN_INT, rs2 = -1, DIV/REM only): quotient = MIN_INT; remainder = 0.
- Latency, counted from the accept edge at cycle T:
  - Normal ops: out_valid first high in cycle T+1+XLEN/UNROLL. CALC lasts exactly XLEN/UNROLL cycles, tracked by a counter sized for XLEN/UNROLL.
  - Special cases: out_valid high in cycle T+1.
  - Sign fixup is registered on the CALC→DONE edge.
- DONE:
  - out_valid, out_result and out_tag are held stable until out_ready=1.
  - DONE & out_ready → IDLE next cycle, with out_valid=0.
  - out_result and out_tag keep their last value while out_valid=0.
- flush:
  - From any state, go to IDLE next cycle with out_valid=0; the result is discarded.
  - Flush beats an accept in the same cycle: the request is not taken, and in_ready stays 1 in that cycle.
  - Flush while in DONE with out_ready=1 counts as consumed; there is no double report.
- rst has priority over flush. rst mid-CALC aborts the operation, with outputs at their reset values next cycle.
- Unknown funct3 is impossible because all 8 encodings are valid. The opcode/funct7 qualification is the caller's responsibility.

Test Plan:
- XLEN=32, UNROLL=1: MUL 7 × 0xFFFFFFFD (−3), out_ready=1 → out_result=0xFFFFFFEB, out_valid in cycle T+33 for exactly 1 cycle, tag echoed.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; REM same operands → 0. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- REM 0xFFFFFFF9 (−7) % 2 → 0xFFFFFFFF. DIV −7/2 → 0xFFFFFFFD. Repeat with UNROLL=4: same results at T+9.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, out_result and out_tag stable, in_ready=0. Release → IDLE, in_ready=1 next cycle.
- Flush at CALC cycle 5 → out_valid never asserts, in_ready=1 next cycle. A new DIVU 100/7 then returns 14 with the new tag. rst mid-CALC behaves the same, with out_result=0.
